demux4out_stream: RTL and testbench
===================================

Name: demux4out_stream

Overview:
- 1-to-4 stream demultiplexer. It is the distribution counterpart of the 4-input select mux.
- One input valid/ready stream carries a 2-bit destination select. Each beat is routed to exactly one of four output channels, each with its own valid/ready.
- A registered output stage plus a one-entry skid buffer give 1-cycle latency and full throughput.
- Per-channel saturating beat counters support debug and performance readout.

Parameters:
- DATA_W, 32, width of the data path.
- CNT_W, 16, width of each per-channel beat counter.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- data_i  input  DATA_W  input beat data.
- select_i  input  2  destination channel of the input beat (0..3).
- valid_i  input  1  input beat valid.
- ready_o  output  1  block can accept an input beat.
- data_o  output  DATA_W  output data, shared by all four channels.
- valid_o  output  4  one-hot output valid; bit n is channel n.
- ready_i  input  4  per-channel sink ready.
- clear_i  input  1  synchronous clear of all beat counters.
- cnt_o  output  4*CNT_W  packed counters; channel n at bits [n*CNT_W +: CNT_W].

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- State:
  - Output register: out_v, out_d, out_s.
  - Skid register: sk_v, sk_d, sk_s.
  - Four counters.
- Reset: all state registers cleared. While rst_i is high:
  - valid_o = 4'b0000.
  - data_o = 0.
  - cnt_o = 0.
  - ready_o = 0.
  - First cycle after reset: ready_o = 1.
- Reset mid-operation: beats held in the output or skid register are discarded and never presented.
- in_fire = valid_i & ready_o.
- ready_o = ~sk_v & ~rst_i. It depends only on registered state, with no combinational path from ready_i.
- valid_o = out_v ? (4'b0001 << out_s) : 4'b0000. data_o = out_d.
- out_fire = out_v & ready_i[out_s]. ready_i bits of non-selected channels are ignored.
- Output stage loads when (~out_v | out_fire):
  - If sk_v: load skid contents into the output register; sk_v <= 0. ready_o = 0 that cycle, so no input is accepted.
  - Else if in_fire: load {data_i, select_i}; out_v <= 1.
  - Else: out_v <= 0.
- When out_v & ~out_fire & in_fire: the input beat is captured in the skid register; sk_v <= 1.
- Latency: a beat accepted in cycle t appears on valid_o/data_o in cycle t+1 if the output stage was free.
- Throughput: 1 beat per cycle while the selected sink stays ready.
- Ordering: strict input order across all channels. A stalled head beat blocks beats for other channels (head-of-line blocking by design).
- Output stability: while valid_o != 0 and the selected sink is not ready, data_o and valid_o hold stable.
- A select value is never changed while presented.
- Counters:
  - On out_fire, counter[out_s] increments by 1, saturating at 2^CNT_W-1.
  - clear_i sets all counters to 0 and takes priority over a same-cycle increment.
  - clear_i has no effect on the datapath.
- Boundary:
  - Skid full with output stalled: ready_o = 0; input holds.
  - Output fire and skid drain in the same cycle: no bubble if the skid holds a beat.
  - valid_i with X select while ready_o = 0: ignored.

Test Plan:
1. Reset then single beat: data_i=32'hA5A5_0001, select_i=2, valid_i one cycle, ready_i=4'hF.
   -> valid_o=4'b0100 and data_o=A5A5_0001 in the next cycle.
   -> cnt_o channel 2 = 1; all other counters 0.
2. Back-to-back stream: 8 beats, selects 0,1,2,3,0,1,2,3, ready_i=4'hF.
   -> ready_o stays 1; outputs appear in order on consecutive cycles.
   -> every counter = 2.
3. Backpressure: ready_i[1]=0; send beats with select 1,3,0.
   -> first beat held on valid_o=4'b0010; second beat goes to skid; ready_o=0 the next cycle.
   -> valid_o[3] does not assert until ready_i[1] rises.
   -> afterwards the 3 beats arrive in order with no loss.
4. Saturation and clear with CNT_W=4: 20 beats to channel 0.
   -> counter 0 = 15.
   -> clear_i asserted in the same cycle as an out_fire -> counter 0 = 0.
5. Reset mid-operation: output and skid both full (ready_i=0), then assert rst_i one cycle.
   -> valid_o=0 and ready_o=0 during reset.
   -> ready_o=1 after reset; no stale beat is ever presented.
6. Random select/valid/ready for 10k cycles against a scoreboard.
   -> per-channel order and data match; no beat is dropped or duplicated.
   -> data_o is stable under stall.

Source files
------------

// File: rtl/demux4out_stream_if.sv
// Valid/ready stream bundle: N=1 for the upstream side, N=4 for the one-hot demuxed side.
// select travels with the data so a sink can see which channel a beat belongs to.
interface demux4out_stream_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N      = 1
);
  logic [DATA_W-1:0] data;
  logic [1:0]        select;
  logic [N-1:0]      valid;
  logic [N-1:0]      ready;

  modport master (output data, output select, output valid, input  ready);
  modport slave  (input  data, input  select, input  valid, output ready);
endinterface

// File: rtl/demux4out_stream.sv
// 1-to-4 stream demultiplexer: registered output stage plus one-entry skid buffer,
// strict input ordering, and per-channel saturating beat counters.
module demux4out_stream #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  demux4out_stream_if.slave      up_i,
  demux4out_stream_if.master     dn_o,
  input  logic                   clear_i,
  output logic [4*CNT_W-1:0]     cnt_o
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
  } beat_t;

  typedef logic [N_CH-1:0][CNT_W-1:0] cnt_arr_t;

  beat_t    out_beat_q, out_beat_d;
  logic     out_v_q,    out_v_d;
  beat_t    sk_beat_q,  sk_beat_d;
  logic     sk_v_q,     sk_v_d;
  cnt_arr_t cnt_q,      cnt_d;

  logic  ready_c;
  logic  in_fire_c;
  logic  out_fire_c;
  beat_t in_beat_c;

  // Accept only while the skid is empty; never a function of the sink readies.
  assign ready_c    = ~sk_v_q & ~rst_i;
  assign in_fire_c  = up_i.valid[0] & ready_c;
  assign out_fire_c = out_v_q & dn_o.ready[out_beat_q.sel];
  assign in_beat_c  = '{data: up_i.data, sel: up_i.select};

  // Datapath next state: skid drains first so ordering is preserved.
  always_comb begin
    out_beat_d = out_beat_q;
    out_v_d    = out_v_q;
    sk_beat_d  = sk_beat_q;
    sk_v_d     = sk_v_q;

    if (!out_v_q || out_fire_c) begin
      if (sk_v_q) begin
        out_beat_d = sk_beat_q;
        out_v_d    = 1'b1;
        sk_v_d     = 1'b0;
      end else if (in_fire_c) begin
        out_beat_d = in_beat_c;
        out_v_d    = 1'b1;
      end else begin
        out_v_d    = 1'b0;
      end
    end else if (in_fire_c) begin
      sk_beat_d = in_beat_c;
      sk_v_d    = 1'b1;
    end
  end

  // Saturating beat counters; clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned n = 0; n < N_CH; n++) begin
      if (clear_i) begin
        cnt_d[n] = '0;
      end else if (out_fire_c && (out_beat_q.sel == SEL_W'(n)) && (cnt_q[n] != {CNT_W{1'b1}})) begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_beat_q <= '0;
      out_v_q    <= 1'b0;
      sk_beat_q  <= '0;
      sk_v_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_beat_q <= out_beat_d;
      out_v_q    <= out_v_d;
      sk_beat_q  <= sk_beat_d;
      sk_v_q     <= sk_v_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  assign up_i.ready  = ready_c;
  assign dn_o.valid  = (out_v_q && !rst_i) ? (N_CH'(1) << out_beat_q.sel) : '0;
  assign dn_o.data   = rst_i ? '0 : out_beat_q.data;
  assign dn_o.select = rst_i ? '0 : out_beat_q.sel;
  assign cnt_o       = rst_i ? '0 : cnt_q;

endmodule

// File: tb/tb_demux4out_stream.sv
// Bench for demux4out_stream: vector table, directed corner sequences, and a
// randomized run against an in-order queue model.
module tb_demux4out_stream;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clr;
  logic [4*CNT_W-1:0]   cnt;

  demux4out_stream_if #(.DATA_W(DATA_W), .N(1)) up ();
  demux4out_stream_if #(.DATA_W(DATA_W), .N(4)) dn ();

  demux4out_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .up_i    (up),
    .dn_o    (dn),
    .clear_i (clr),
    .cnt_o   (cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Advance one cycle, drive inputs, then let combinational outputs settle.
  task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                      input logic [3:0] r, input logic c, input logic rs);
    @(posedge clk);
    #1;
    up.valid  = v;
    up.select = s;
    up.data   = d;
    dn.ready  = r;
    clr       = c;
    rst       = rs;
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  s;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic        e_rdy;
    logic [3:0]  e_val;
    logic [31:0] e_dat;
    logic        chk_cnt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [31:0] d,
                              input logic [3:0] rdy, input logic e_rdy, input logic [3:0] e_val,
                              input logic [31:0] e_dat, input logic chk_cnt, input logic [15:0] e_cnt);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.rdy = rdy;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_dat = e_dat;
    t.chk_cnt = chk_cnt; t.e_cnt = e_cnt;
    return t;
  endfunction

  // Reference model: the block behaves as a 2-deep in-order queue.
  typedef struct { logic [1:0] s; logic [31:0] d; } beat_t;
  beat_t mq[$];
  int    mcnt[4];

  function automatic logic [15:0] model_cnt();
    return {4'(mcnt[3]), 4'(mcnt[2]), 4'(mcnt[1]), 4'(mcnt[0])};
  endfunction

  task automatic rstep(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] r, input logic c);
    logic       m_rdy;
    logic [3:0] e_val;
    logic       ofire;
    logic       ifire;
    beat_t      b;
    m_rdy = (mq.size() < 2);
    step(v, m_rdy ? s : 2'bxx, d, r, c, 1'b0);
    e_val = (mq.size() > 0) ? 4'(1 << mq[0].s) : 4'b0000;
    chk("rnd_ready", 64'(up.ready), 64'(m_rdy));
    chk("rnd_valid", 64'(dn.valid), 64'(e_val));
    if (mq.size() > 0) chk("rnd_data", 64'(dn.data), 64'(mq[0].d));
    chk("rnd_cnt", 64'(cnt), 64'(model_cnt()));
    ofire = (mq.size() > 0) && r[mq[0].s];
    ifire = v && m_rdy;
    if (c) begin
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
    end else if (ofire && mcnt[mq[0].s] < int'(CNT_MAX)) begin
      mcnt[mq[0].s]++;
    end
    if (ofire) void'(mq.pop_front());
    if (ifire) begin
      b.s = s;
      b.d = d;
      mq.push_back(b);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    up.valid = 1'b0; up.select = 2'd0; up.data = '0; dn.ready = 4'h0;

    // Vector table: test 1, back-to-back stream, backpressure with skid.
    vecs.push_back(mk(1, 2, 32'hA5A5_0001, 4'hF, 1, 4'b0000, 32'h0, 0, 16'h0));
    vecs.push_back(mk(0, 0, 32'h0,         4'hF, 1, 4'b0100, 32'hA5A5_0001, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 32'h0,         4'hF, 1, 4'b0000, 32'h0, 1, 16'h0100));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(1, 2'(k % 4), 32'h1000_0000 + 32'(k), 4'hF, 1,
                        (k == 0) ? 4'b0000 : 4'(1 << ((k - 1) % 4)),
                        (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k - 1), 0, 16'h0));
    end
    vecs.push_back(mk(0, 0, 32'h0, 4'hF, 1, 4'b1000, 32'h1000_0007, 0, 16'h0));
    vecs.push_back(mk(0, 0, 32'h0, 4'hF, 1, 4'b0000, 32'h0, 1, 16'h2322));
    vecs.push_back(mk(1, 1, 32'hB1, 4'hD, 1, 4'b0000, 32'h0,  0, 16'h0));
    vecs.push_back(mk(1, 3, 32'hB3, 4'hD, 1, 4'b0010, 32'hB1, 0, 16'h0));
    vecs.push_back(mk(1, 0, 32'hB0, 4'hD, 0, 4'b0010, 32'hB1, 0, 16'h0));
    vecs.push_back(mk(1, 0, 32'hB0, 4'hD, 0, 4'b0010, 32'hB1, 0, 16'h0));
    vecs.push_back(mk(1, 0, 32'hB0, 4'hF, 0, 4'b0010, 32'hB1, 0, 16'h0));
    vecs.push_back(mk(1, 0, 32'hB0, 4'hF, 1, 4'b1000, 32'hB3, 0, 16'h0));
    vecs.push_back(mk(0, 0, 32'h0,  4'hF, 1, 4'b0001, 32'hB0, 0, 16'h0));
    vecs.push_back(mk(0, 0, 32'h0,  4'hF, 1, 4'b0000, 32'h0,  1, 16'h3333));

    step(0, 0, 0, 4'hF, 0, 1'b1);
    step(0, 0, 0, 4'hF, 0, 1'b1);
    chk("rst_valid", 64'(dn.valid), 64'h0);
    chk("rst_ready", 64'(up.ready), 64'h0);
    chk("rst_data",  64'(dn.data),  64'h0);
    chk("rst_cnt",   64'(cnt),      64'h0);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].rdy, 1'b0, 1'b0);
      chk($sformatf("vec%0d_ready", i), 64'(up.ready), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_valid", i), 64'(dn.valid), 64'(vecs[i].e_val));
      if (vecs[i].e_val != 4'b0000)
        chk($sformatf("vec%0d_data", i), 64'(dn.data), 64'(vecs[i].e_dat));
      if (vecs[i].chk_cnt)
        chk($sformatf("vec%0d_cnt", i), 64'(cnt), 64'(vecs[i].e_cnt));
    end

    // Saturation: channel 0 climbs from 3 past 15 and sticks.
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 32'hC000_0000 + 32'(k), 4'hF, 0, 1'b0);
      chk("sat_ready", 64'(up.ready), 64'h1);
    end
    step(0, 0, 0, 4'hF, 0, 1'b0);
    chk("sat_last_data", 64'(dn.data), 64'hC000_0013);
    step(0, 0, 0, 4'hF, 0, 1'b0);
    chk("sat_cnt", 64'(cnt), 64'h333F);

    // Clear coincides with an output fire: clear wins, datapath unaffected.
    step(1, 0, 32'hE0, 4'hF, 0, 1'b0);
    step(0, 0, 0, 4'hF, 1, 1'b0);
    chk("clr_valid", 64'(dn.valid), 64'h1);
    chk("clr_data",  64'(dn.data),  64'hE0);
    step(0, 0, 0, 4'hF, 0, 1'b0);
    chk("clr_cnt",   64'(cnt),      64'h0);
    chk("clr_idle",  64'(dn.valid), 64'h0);

    // Reset with output and skid both full: held beats must vanish.
    step(1, 2, 32'hC0, 4'h0, 0, 1'b0);
    step(1, 1, 32'hC1, 4'h0, 0, 1'b0);
    chk("full_ready0", 64'(up.ready), 64'h1);
    chk("full_valid0", 64'(dn.valid), 64'h4);
    step(0, 0, 0, 4'h0, 0, 1'b0);
    chk("full_ready1", 64'(up.ready), 64'h0);
    chk("full_data1",  64'(dn.data),  64'hC0);
    step(0, 0, 0, 4'h0, 0, 1'b1);
    chk("mrst_valid", 64'(dn.valid), 64'h0);
    chk("mrst_ready", 64'(up.ready), 64'h0);
    chk("mrst_data",  64'(dn.data),  64'h0);
    step(0, 0, 0, 4'hF, 0, 1'b0);
    chk("post_ready", 64'(up.ready), 64'h1);
    chk("post_valid", 64'(dn.valid), 64'h0);
    step(0, 0, 0, 4'hF, 0, 1'b0);
    chk("post_stale", 64'(dn.valid), 64'h0);
    step(1, 3, 32'hD0, 4'hF, 0, 1'b0);
    chk("post_stale2", 64'(dn.valid), 64'h0);
    step(0, 0, 0, 4'hF, 0, 1'b0);
    chk("post_valid2", 64'(dn.valid), 64'h8);
    chk("post_data2",  64'(dn.data),  64'hD0);

    // Randomized run against the queue model.
    step(0, 0, 0, 4'hF, 0, 1'b1);
    mq.delete();
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    for (int i = 0; i < 10000; i++) begin
      rstep(($urandom % 10) < 7, 2'($urandom), $urandom, 4'($urandom), ($urandom % 256) == 0);
    end
    for (int i = 0; i < 4; i++) rstep(1'b0, 2'd0, 32'h0, 4'hF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
